// File: rtl/blake_round_scheduler_if.sv
// Handshake and datapath-control bundle between the BLAKE-512 round scheduler and its neighbours.
// BLAKE_STALL_EN adds the stall input used to freeze the round sequence.
interface blake_round_scheduler_if;
  logic       blk_valid;
  logic       blk_last;
  logic       abort;
`ifdef BLAKE_STALL_EN
  logic       stall;
`endif
  logic       blk_ready;
  logic       load_state;
  logic       round_ing;
  logic       step_en;
  logic [3:0] round_idx;
  logic [3:0] sigma_row;
  logic       half;
  logic       finalize;
  logic       digest_valid;
  logic       busy;

`ifdef BLAKE_STALL_EN
  modport master (
    output blk_valid, blk_last, abort, stall,
    input  blk_ready, load_state, round_ing, step_en, round_idx, sigma_row,
           half, finalize, digest_valid, busy
  );
  modport slave (
    input  blk_valid, blk_last, abort, stall,
    output blk_ready, load_state, round_ing, step_en, round_idx, sigma_row,
           half, finalize, digest_valid, busy
  );
`else
  modport master (
    output blk_valid, blk_last, abort,
    input  blk_ready, load_state, round_ing, step_en, round_idx, sigma_row,
           half, finalize, digest_valid, busy
  );
  modport slave (
    input  blk_valid, blk_last, abort,
    output blk_ready, load_state, round_ing, step_en, round_idx, sigma_row,
           half, finalize, digest_valid, busy
  );
`endif
endinterface

// File: rtl/blake_round_scheduler.sv
// Sequences one BLAKE-512 compression per accepted block: init, ROUNDS column/diagonal pairs, finalize.
// Optional `define BLAKE_STALL_EN adds a stall input that freezes the half-round sequence.
module blake_round_scheduler #(
  parameter int ROUNDS = 16
) (
  input logic                    clk,
  input logic                    rstb,
  blake_round_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, INIT, ROUND, FINAL} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_roundIdx;
  logic [3:0] r_sigmaRow;
  logic       r_half;
  logic       r_last;

  logic       w_stall;
  logic       w_accept;
  logic       w_advance;
  logic       w_lastStep;
  logic       w_abortBusy;

  logic       w_blkReady;
  logic       w_loadState;
  logic       w_roundIng;
  logic       w_stepEn;
  logic       w_finalize;
  logic       w_digestValid;
  logic       w_busy;

`ifdef BLAKE_STALL_EN
  assign w_stall = bus.stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_accept    = (r_state == IDLE) && bus.blk_valid && !bus.abort;
  assign w_advance   = (r_state == ROUND) && !w_stall;
  assign w_lastStep  = r_half && (r_roundIdx == LAST_ROUND);
  assign w_abortBusy = bus.abort && (r_state != IDLE);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // abort outranks every transition, including a pending last step
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = INIT;
      INIT:    w_nextState = ROUND;
      ROUND:   if (w_advance && w_lastStep) w_nextState = FINAL;
      FINAL:   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (w_abortBusy) begin
      w_nextState = IDLE;
    end
  end

  // Counters freeze on the final half-round so FINAL still shows round ROUNDS-1, half 1
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_roundIdx <= 4'd0;
      r_sigmaRow <= 4'd0;
      r_half     <= 1'b0;
      r_last     <= 1'b0;
    end else if (w_abortBusy) begin
      r_roundIdx <= 4'd0;
      r_sigmaRow <= 4'd0;
      r_half     <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_last <= bus.blk_last;
          end
        end
        INIT: begin
          r_roundIdx <= 4'd0;
          r_sigmaRow <= 4'd0;
          r_half     <= 1'b0;
        end
        ROUND: begin
          if (w_advance && !w_lastStep) begin
            r_half <= !r_half;
            if (r_half) begin
              r_roundIdx <= r_roundIdx + 4'd1;
              r_sigmaRow <= (r_sigmaRow == 4'd9) ? 4'd0 : r_sigmaRow + 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // An abort arriving in FINAL suppresses that cycle's finalize and digest pulses
  always_comb begin
    w_blkReady    = (r_state == IDLE) && !bus.abort;
    w_loadState   = (r_state == INIT);
    w_roundIng    = (r_state == ROUND);
    w_stepEn      = (r_state == ROUND) && !w_stall;
    w_finalize    = (r_state == FINAL) && !bus.abort;
    w_digestValid = (r_state == FINAL) && !bus.abort && r_last;
    w_busy        = (r_state != IDLE);
  end

  assign bus.blk_ready    = w_blkReady;
  assign bus.load_state   = w_loadState;
  assign bus.round_ing    = w_roundIng;
  assign bus.step_en      = w_stepEn;
  assign bus.round_idx    = r_roundIdx;
  assign bus.sigma_row    = r_sigmaRow;
  assign bus.half         = r_half;
  assign bus.finalize     = w_finalize;
  assign bus.digest_valid = w_digestValid;
  assign bus.busy         = w_busy;

endmodule

// File: tb/tb_blake_round_scheduler.sv
// Scoreboard bench for blake_round_scheduler: the stimulus side predicts every load/step/finalize pulse
// with its cycle and fields; a negedge monitor pops and compares whenever the DUT emits one.
module tb_blake_round_scheduler;
  localparam int R = 16;

  localparam int K_LOAD = 0;
  localparam int K_STEP = 1;
  localparam int K_FIN  = 2;

  localparam int M_NONE       = 0;
  localparam int M_ABORT_INIT = 1;
  localparam int M_ABORT_STEP = 2;
  localparam int M_ABORT_FIN  = 3;
  localparam int M_RESET_STEP = 4;
  localparam int M_IDLE_ABORT = 5;

  typedef struct {
    int kind;
    int whenCyc;
    int rnd;
    int sig;
    int hf;
    int dig;
  } ev_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  int   cyc = 0;
  int   nTests = 0;
  int   nFail = 0;
  ev_t  expQ[$];
  int   stallStep = -1;
  int   stallLeft = 0;
  bit   randStall = 1'b0;

  blake_round_scheduler_if bus();

  blake_round_scheduler #(.ROUNDS(R)) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Step k of a compression is round k/2, half k%2, using sigma row (k/2) mod 10
  function automatic ev_t mkEvent(input int kind, input int whenCyc, input int k, input int dig);
    ev_t e;
    e.kind    = kind;
    e.whenCyc = whenCyc;
    e.rnd     = k / 2;
    e.sig     = (k / 2) % 10;
    e.hf      = k % 2;
    e.dig     = dig;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    int kind;
    int nPulses;
    ev_t e;
    if (rstb === 1'b1) begin
      nPulses = int'(bus.load_state) + int'(bus.step_en) + int'(bus.finalize);
      if (nPulses > 1) checkOutput("pulseOverlap", nPulses, 1);
      if (bus.digest_valid && !bus.finalize) checkOutput("digestWithoutFinalize", 1, 0);
`ifndef BLAKE_STALL_EN
      if (bus.round_ing !== bus.step_en) checkOutput("stepEqualsRoundIng", bus.step_en, bus.round_ing);
`endif
      kind = bus.load_state ? K_LOAD : bus.step_en ? K_STEP : bus.finalize ? K_FIN : -1;
      if (kind >= 0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedPulse", kind, -1);
        end else begin
          e = expQ.pop_front();
          checkOutput("pulseKind", kind, e.kind);
          checkOutput("pulseCycle", cyc, e.whenCyc);
          if (e.kind == K_STEP && kind == K_STEP) begin
            checkOutput("roundIdx", bus.round_idx, e.rnd);
            checkOutput("sigmaRow", bus.sigma_row, e.sig);
            checkOutput("half", bus.half, e.hf);
          end
          if (e.kind == K_FIN && kind == K_FIN) begin
            checkOutput("digestValid", bus.digest_valid, e.dig);
          end
        end
      end
    end
  end

  task automatic checkIdleCleared(input string tag);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_roundIdx"}, bus.round_idx, 0);
    checkOutput({tag, "_half"}, bus.half, 0);
    checkOutput({tag, "_sigma"}, bus.sigma_row, 0);
  endtask

  // Entered and left at posedge+1 of an IDLE cycle; the accept edge is the next posedge.
  // Monitor cycle stamp for spec cycle n (n>=1 after the accept edge) is acceptCyc + n - 1.
  task automatic applyStimulus(input bit last, input int mode, input int where);
    int  p;
    int  t;
    int  k;
    bit  st;
    bus.blk_valid = 1'b1;
    bus.blk_last  = last;
    bus.abort     = (mode == M_IDLE_ABORT);
    #1;
    checkOutput("readyIdle", bus.blk_ready, (mode == M_IDLE_ABORT) ? 0 : 1);
    checkOutput("busyIdle", bus.busy, 0);
    @(posedge clk); #1;
    bus.blk_valid = 1'b0;
    bus.blk_last  = 1'(($urandom));
    bus.abort     = 1'b0;
    if (mode == M_IDLE_ABORT) begin
      #1 checkOutput("noAcceptOnAbort", bus.busy, 0);
      return;
    end
    p = cyc;
    expQ.push_back(mkEvent(K_LOAD, p, 0, 0));
    if (mode == M_ABORT_INIT) begin
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      checkIdleCleared("abortInit");
      return;
    end
    @(posedge clk); #1;
    t = p + 1;
    k = 0;
    while (k < 2 * R) begin
      st = 1'b0;
`ifdef BLAKE_STALL_EN
      if (k == stallStep && stallLeft > 0) begin
        st = 1'b1;
        stallLeft--;
      end else if (randStall && $urandom_range(0, 3) == 0) begin
        st = 1'b1;
      end
      bus.stall = st;
`endif
      if (mode == M_RESET_STEP && k == where && !st) begin
        rstb = 1'b0;
        #1;
        checkIdleCleared("asyncReset");
        checkOutput("resetRoundIng", bus.round_ing, 0);
        checkOutput("resetStepEn", bus.step_en, 0);
        checkOutput("resetFinalize", bus.finalize, 0);
        @(posedge clk); #1;
        rstb = 1'b1;
`ifdef BLAKE_STALL_EN
        bus.stall = 1'b0;
`endif
        #1 checkOutput("readyAfterReset", bus.blk_ready, 1);
        return;
      end
      if (mode == M_ABORT_STEP && k == where && !st) bus.abort = 1'b1;
      if (!st) begin
        expQ.push_back(mkEvent(K_STEP, t, k, 0));
      end else begin
        #1;
        checkOutput("stallStepEn", bus.step_en, 0);
        checkOutput("stallRoundIng", bus.round_ing, 1);
      end
      t++;
      if (bus.abort) begin
        @(posedge clk); #1;
        bus.abort = 1'b0;
`ifdef BLAKE_STALL_EN
        bus.stall = 1'b0;
`endif
        checkIdleCleared("abortStep");
        return;
      end
      if (!st) k++;
      @(posedge clk); #1;
    end
`ifdef BLAKE_STALL_EN
    bus.stall = 1'(($urandom));
`endif
    if (mode == M_ABORT_FIN) bus.abort = 1'b1;
    else expQ.push_back(mkEvent(K_FIN, t, 2 * R - 1, last));
    @(posedge clk); #1;
    bus.abort = 1'b0;
`ifdef BLAKE_STALL_EN
    bus.stall = 1'b0;
`endif
    if (mode == M_ABORT_FIN) checkIdleCleared("abortFinal");
  endtask

  initial begin
    int mode;
    int r;
    bus.blk_valid = 1'b0;
    bus.blk_last  = 1'b0;
    bus.abort     = 1'b0;
`ifdef BLAKE_STALL_EN
    bus.stall     = 1'b0;
`endif
    rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleCleared("reset");
    checkOutput("resetLoad", bus.load_state, 0);
    checkOutput("resetRoundIng", bus.round_ing, 0);
    checkOutput("resetStepEn", bus.step_en, 0);
    checkOutput("resetFinalize", bus.finalize, 0);
    checkOutput("resetDigest", bus.digest_valid, 0);
    rstb = 1'b1;
    #1 checkOutput("readyAfterRelease", bus.blk_ready, 1);
    @(posedge clk); #1;

    applyStimulus(1'b1, M_NONE, 0);
    applyStimulus(1'b0, M_NONE, 0);
    applyStimulus(1'b1, M_NONE, 0);
    applyStimulus(1'b1, M_ABORT_STEP, 11);
    applyStimulus(1'b1, M_NONE, 0);
    applyStimulus(1'b1, M_RESET_STEP, 16);
    applyStimulus(1'b1, M_IDLE_ABORT, 0);
    applyStimulus(1'b0, M_ABORT_INIT, 0);
    applyStimulus(1'b1, M_ABORT_FIN, 0);
    applyStimulus(1'b1, M_NONE, 0);
`ifdef BLAKE_STALL_EN
    stallStep = 4;
    stallLeft = 3;
    applyStimulus(1'b1, M_NONE, 0);
    stallStep = -1;
    randStall = 1'b1;
`endif

    repeat (24) begin
      r = $urandom_range(0, 9);
      mode = (r < 5) ? M_NONE : r - 4;
      applyStimulus(1'($urandom), mode, $urandom_range(0, 2 * R - 1));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    #1 checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
